// File: rtl/pipe_pkg.sv
// Shared opcodes and pipeline bookkeeping for pipe_param_core and its register file.
package pipe_pkg;

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  // A stage holds a bubble when its valid bit is clear; its payload is then don't-care.
  localparam logic BUBBLE = 1'b0;

  // Bit positions within the stage-valid vector (IF has no valid of its own).
  localparam int unsigned STG_ID  = 0;
  localparam int unsigned STG_EX  = 1;
  localparam int unsigned STG_WB  = 2;
  localparam int unsigned NUM_STG = 3;

  function automatic logic op_writes(input logic [1:0] op);
    return op != OP_JMP;
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// NREG x DATA_W register file: two read ports plus a debug port, one write port.
// Reads see a same-cycle write (write-through), so ID never needs a stall.
module pipe_regfile
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG = 2 ** RA_W;

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a  = (we && (waddr == raddr_a))  ? wdata : regs_q[raddr_a];
    rdata_b  = (we && (waddr == raddr_b))  ? wdata : regs_q[raddr_b];
    dbg_data = (we && (waddr == dbg_addr)) ? wdata : regs_q[dbg_addr];
  end

endmodule

// File: rtl/pipe_param_core.sv
// Parametrised 4-stage in-order core (IF, ID, EX, WB) with fetch handshake,
// WB->EX forwarding, write-through register file and a one-slot jump squash.
module pipe_param_core
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RA_W    = 3,
  parameter int unsigned IMM_W   = 3,
  parameter int unsigned PC_W    = 8,
  localparam int unsigned INST_W = 2 + RA_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic              ret_valid,
  output logic [RA_W-1:0]   ret_rd,
  output logic [DATA_W-1:0] ret_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned FLD_W = RA_W + IMM_W;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INST_W-1:0]  ifid_inst_q, ifid_inst_d;
  logic [NUM_STG-1:0] stg_valid_q, stg_valid_d;

  logic [1:0]         idex_op_q;
  logic [RA_W-1:0]    idex_rd_q, idex_rs_q;
  logic [DATA_W-1:0]  idex_imm_q, idex_a_q, idex_b_q;

  logic               exwb_we_q;
  logic [RA_W-1:0]    exwb_rd_q;
  logic [DATA_W-1:0]  exwb_data_q;

  // ID decode
  logic [1:0]         id_op;
  logic [RA_W-1:0]    id_rd, id_rs;
  logic [IMM_W-1:0]   id_imm;
  logic [DATA_W-1:0]  id_imm_sext, id_a, id_b;
  logic [FLD_W-1:0]   id_field;
  logic [PC_W-1:0]    jmp_target;
  logic               id_jmp;

  // EX / WB
  logic [DATA_W-1:0]  ex_a, ex_b, ex_result;
  logic               wb_we;

  assign id_op       = ifid_inst_q[INST_W-1 -: 2];
  assign id_rd       = ifid_inst_q[IMM_W +: RA_W];
  assign id_imm      = ifid_inst_q[IMM_W-1:0];
  assign id_rs       = id_imm[RA_W-1:0];
  assign id_field    = ifid_inst_q[FLD_W-1:0];
  assign id_imm_sext = DATA_W'($signed(id_imm));
  assign id_jmp      = stg_valid_q[STG_ID] && (id_op == OP_JMP);

  assign wb_we       = stg_valid_q[STG_WB] && exwb_we_q;

  // While the JMP sits in ID, pc_q already holds pc_jmp + 1.
  if (PC_W <= FLD_W) begin : g_tgt_trunc
    assign jmp_target = id_field[PC_W-1:0];
  end else begin : g_tgt_ext
    assign jmp_target = {pc_q[PC_W-1:FLD_W], id_field};
  end

  pipe_regfile #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (exwb_rd_q),
    .wdata    (exwb_data_q),
    .raddr_a  (id_rd),
    .rdata_a  (id_a),
    .raddr_b  (id_rs),
    .rdata_b  (id_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Fetch / squash / stage-valid advance
  always_comb begin
    pc_d                = pc_q;
    ifid_inst_d         = ifid_inst_q;
    stg_valid_d         = stg_valid_q;
    stg_valid_d[STG_ID] = BUBBLE;
    if (id_jmp) begin
      pc_d = jmp_target;
    end else if (imem_valid) begin
      ifid_inst_d         = imem_rdata;
      stg_valid_d[STG_ID] = 1'b1;
      pc_d                = pc_q + PC_W'(1);
    end
    stg_valid_d[STG_EX] = stg_valid_q[STG_ID];
    stg_valid_d[STG_WB] = stg_valid_q[STG_EX];
  end

  // Execute with operands forwarded from the instruction currently writing back
  always_comb begin
    ex_a = (wb_we && (exwb_rd_q == idex_rd_q)) ? exwb_data_q : idex_a_q;
    ex_b = (wb_we && (exwb_rd_q == idex_rs_q)) ? exwb_data_q : idex_b_q;
    case (idex_op_q)
      OP_LDI:  ex_result = idex_imm_q;
      OP_ADDI: ex_result = ex_a + idex_imm_q;
      OP_ADD:  ex_result = ex_a + ex_b;
      default: ex_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      ifid_inst_q <= '0;
      stg_valid_q <= {NUM_STG{BUBBLE}};
      idex_op_q   <= OP_LDI;
      idex_rd_q   <= '0;
      idex_rs_q   <= '0;
      idex_imm_q  <= '0;
      idex_a_q    <= '0;
      idex_b_q    <= '0;
      exwb_we_q   <= 1'b0;
      exwb_rd_q   <= '0;
      exwb_data_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_inst_q <= ifid_inst_d;
      stg_valid_q <= stg_valid_d;
      idex_op_q   <= id_op;
      idex_rd_q   <= id_rd;
      idex_rs_q   <= id_rs;
      idex_imm_q  <= id_imm_sext;
      idex_a_q    <= id_a;
      idex_b_q    <= id_b;
      exwb_we_q   <= op_writes(idex_op_q);
      exwb_rd_q   <= idex_rd_q;
      exwb_data_q <= ex_result;
    end
  end

  assign imem_addr = pc_q;
  assign ret_valid = wb_we;
  assign ret_rd    = exwb_rd_q;
  assign ret_data  = exwb_data_q;

endmodule

// File: tb/tb_pipe_param_core.sv
// Bench for pipe_param_core: an instruction-level model of the ISA produces the
// expected retire stream and register state; directed programs check timing.
module tb_pipe_param_core;

  localparam int DATA_W = 8;
  localparam int RA_W   = 3;
  localparam int IMM_W  = 3;
  localparam int PC_W   = 8;
  localparam int INST_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              imem_valid;
  logic              ret_valid;
  logic [RA_W-1:0]   ret_rd;
  logic [DATA_W-1:0] ret_data;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  pipe_param_core #(
    .DATA_W (DATA_W),
    .RA_W   (RA_W),
    .IMM_W  (IMM_W),
    .PC_W   (PC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ret_valid  (ret_valid),
    .ret_rd     (ret_rd),
    .ret_data   (ret_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } ret_t;

  int   checks   = 0;
  int   failures = 0;
  ret_t exp_q[$];
  ret_t obs_q[$];
  int   ret_cyc[$];
  int   addr_log[$];
  logic [7:0] shadow     [8];
  logic [7:0] model_regs [8];

  function automatic logic [7:0] i_ldi(input int rd, input int imm);
    return {2'b00, 3'(rd), 3'(imm)};
  endfunction
  function automatic logic [7:0] i_addi(input int rd, input int imm);
    return {2'b01, 3'(rd), 3'(imm)};
  endfunction
  function automatic logic [7:0] i_add(input int rd, input int rs);
    return {2'b10, 3'(rd), 3'(rs)};
  endfunction
  function automatic logic [7:0] i_jmp(input int field);
    return {2'b11, 6'(field)};
  endfunction

  function automatic ret_t obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return '1;
  endfunction
  function automatic int cyc_at(input int i);
    if (i < ret_cyc.size()) return ret_cyc[i];
    return -1;
  endfunction
  function automatic int addr_at(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return -1;
  endfunction

  task automatic mem_fill(input bit rnd);
    for (int i = 0; i < 256; i++) mem[i] = rnd ? 8'($urandom) : 8'h00;
  endtask

  // Architectural execution from PC 0: one instruction per step, JMP retires nothing.
  task automatic model_run(input int steps);
    int pc, rd, simm, val;
    logic [7:0] inst;
    pc = 0;
    exp_q.delete();
    for (int r = 0; r < 8; r++) model_regs[r] = 8'h00;
    repeat (steps) begin
      inst = mem[pc];
      rd   = int'(inst[5:3]);
      simm = int'(inst[2:0]);
      if (simm >= 4) simm -= 8;
      if (inst[7:6] == 2'b11) begin
        pc = (((pc + 1) % 256) & 'hC0) | int'(inst[5:0]);
      end else begin
        if (inst[7:6] == 2'b00)      val = simm;
        else if (inst[7:6] == 2'b01) val = int'(model_regs[rd]) + simm;
        else                         val = int'(model_regs[rd]) + int'(model_regs[inst[2:0]]);
        val = val & 255;
        model_regs[rd] = 8'(val);
        exp_q.push_back({3'(rd), 8'(val)});
        pc = (pc + 1) % 256;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    imem_valid = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs ncyc cycles from reset; every retire is matched against the model stream.
  task automatic run_prog(input int ncyc, input int st_lo, input int st_hi,
                          input bit rnd_stall, input bit drain);
    ret_t e;
    model_run(ncyc + 8);
    obs_q.delete();
    ret_cyc.delete();
    addr_log.delete();
    for (int r = 0; r < 8; r++) shadow[r] = 8'h00;
    do_reset(2);
    for (int c = 0; c < ncyc; c++) begin
      addr_log.push_back(int'(imem_addr));
      imem_valid = !((c >= st_lo && c <= st_hi) || (rnd_stall && $urandom_range(0, 3) == 0));
      dbg_addr   = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (ret_valid) begin
        obs_q.push_back({ret_rd, ret_data});
        ret_cyc.push_back(c);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL retire_extra: cyc=%0d got rd=%0d data=%02h, required no retire",
                   c, ret_rd, ret_data);
        end else begin
          e = exp_q.pop_front();
          if ({ret_rd, ret_data} !== e) begin
            failures++;
            $display("FAIL retire_value: cyc=%0d got rd=%0d data=%02h, required rd=%0d data=%02h",
                     c, ret_rd, ret_data, e.rd, e.data);
          end
          shadow[e.rd] = e.data;
        end
      end
      checks++;
      if (dbg_data !== shadow[dbg_addr]) begin
        failures++;
        $display("FAIL dbg_read: cyc=%0d r%0d got %02h, required %02h",
                 c, dbg_addr, dbg_data, shadow[dbg_addr]);
      end
    end
    if (drain) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL retire_missing: got %0d outstanding, required 0", exp_q.size());
      end
    end
  endtask

  task automatic test_reset;
    mem_fill(1'b1);
    @(negedge clk);
    rst = 1'b1;
    imem_valid = 1'b1;
    repeat (2) @(posedge clk);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      @(negedge clk);
      checks++;
      if (dbg_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg: r%0d got %02h, required 00", r, dbg_data);
      end
    end
    rst = 1'b0;
    checks++;
    if (imem_addr !== 8'h00 || ret_valid !== 1'b0 || ret_rd !== 3'd0 || ret_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%02h rv=%b rd=%0d data=%02h, required 00 0 0 00",
               imem_addr, ret_valid, ret_rd, ret_data);
    end
  endtask

  task automatic test_forward;
    mem_fill(1'b0);
    mem[0] = i_ldi(1, 3);
    mem[1] = i_addi(1, 2);
    mem[2] = i_jmp(2);
    run_prog(12, -1, -1, 1'b0, 1'b1);
    checks++;
    if (obs_at(0) !== {3'd1, 8'h03} || obs_at(1) !== {3'd1, 8'h05}) begin
      failures++;
      $display("FAIL forward_values: got %03h %03h, required 103 105", obs_at(0), obs_at(1));
    end
    checks++;
    if (cyc_at(0) != 2 || cyc_at(1) != 3) begin
      failures++;
      $display("FAIL forward_timing: got cycles %0d %0d, required 2 3", cyc_at(0), cyc_at(1));
    end
  endtask

  task automatic test_sign_wrap;
    mem_fill(1'b0);
    mem[0] = i_ldi(2, 7);
    mem[1] = i_addi(2, 1);
    mem[2] = i_jmp(2);
    run_prog(12, -1, -1, 1'b0, 1'b1);
    checks++;
    if (obs_at(0) !== {3'd2, 8'hFF} || obs_at(1) !== {3'd2, 8'h00}) begin
      failures++;
      $display("FAIL sign_wrap: got %03h %03h, required 2ff 200", obs_at(0), obs_at(1));
    end
  endtask

  task automatic test_jump(input int stall_at);
    mem_fill(1'b0);
    mem[0]     = i_ldi(1, 1);
    mem[1]     = i_ldi(2, 2);
    mem[2]     = i_jmp('h10);
    mem[3]     = i_ldi(3, 7);
    mem['h10]  = i_ldi(4, 3);
    mem['h11]  = i_jmp('h11);
    run_prog(16, stall_at, stall_at, 1'b0, 1'b1);
    checks++;
    if (obs_q.size() != 3 || obs_at(2) !== {3'd4, 8'h03}) begin
      failures++;
      $display("FAIL jump_retire: got n=%0d third=%03h, required n=3 third=403",
               obs_q.size(), obs_at(2));
    end
    checks++;
    if (addr_at(3) != 3 || addr_at(4) != 'h10) begin
      failures++;
      $display("FAIL jump_fetch: got addr %0h %0h, required 3 10", addr_at(3), addr_at(4));
    end
    checks++;
    if (cyc_at(2) != 6) begin
      failures++;
      $display("FAIL jump_timing: got cycle %0d, required 6", cyc_at(2));
    end
  endtask

  task automatic test_fetch_stall;
    mem_fill(1'b0);
    mem[0] = i_ldi(1, 1);
    mem[1] = i_addi(1, 1);
    mem[2] = i_ldi(2, 5);
    mem[3] = i_add(1, 2);
    mem[4] = i_addi(2, 3);
    mem[5] = i_jmp(5);
    run_prog(20, 2, 3, 1'b0, 1'b1);
    checks++;
    if (addr_at(2) != 2 || addr_at(3) != 2 || addr_at(4) != 2 || addr_at(5) != 3) begin
      failures++;
      $display("FAIL stall_addr: got %0d %0d %0d %0d, required 2 2 2 3",
               addr_at(2), addr_at(3), addr_at(4), addr_at(5));
    end
    checks++;
    if (obs_q.size() != 5 || cyc_at(1) != 3 || cyc_at(2) != 6) begin
      failures++;
      $display("FAIL stall_retire: got n=%0d cyc1=%0d cyc2=%0d, required n=5 cyc1=3 cyc2=6",
               obs_q.size(), cyc_at(1), cyc_at(2));
    end
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      @(negedge clk);
      checks++;
      if (dbg_data !== model_regs[r]) begin
        failures++;
        $display("FAIL stall_final: r%0d got %02h, required %02h", r, dbg_data, model_regs[r]);
      end
    end
  endtask

  task automatic test_bypass;
    mem_fill(1'b0);
    mem[0] = i_ldi(3, 1);
    mem[1] = i_jmp(2);
    mem[2] = i_add(3, 3);
    mem[3] = i_ldi(5, 2);
    mem[4] = i_ldi(6, 0);
    mem[5] = i_add(5, 5);
    mem[6] = i_jmp(6);
    run_prog(20, -1, -1, 1'b0, 1'b1);
    checks++;
    if (obs_at(1) !== {3'd3, 8'h02} || obs_at(4) !== {3'd5, 8'h04}) begin
      failures++;
      $display("FAIL bypass: got %03h %03h, required 302 504", obs_at(1), obs_at(4));
    end
  endtask

  task automatic test_reset_mid;
    mem_fill(1'b0);
    for (int i = 0; i < 6; i++) mem[i] = i_ldi(i + 1, 1);
    mem[6] = i_jmp(0);
    do_reset(2);
    imem_valid = 1'b1;
    dbg_addr   = 3'd2;
    repeat (5) @(negedge clk);
    checks++;
    if (ret_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: got ret_valid=%b, required 1", ret_valid);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (ret_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_quiet: k=%0d got ret_valid=%b, required 0", k, ret_valid);
      end
    end
    checks++;
    if (dbg_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_regs: r2 got %02h, required 00", dbg_data);
    end
    @(negedge clk);
    checks++;
    if (ret_valid !== 1'b1 || ret_rd !== 3'd1 || ret_data !== 8'h01) begin
      failures++;
      $display("FAIL midrst_restart: got rv=%b rd=%0d data=%02h, required 1 1 01",
               ret_valid, ret_rd, ret_data);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4; n++) begin
      mem_fill(1'b1);
      run_prog(250, -1, -1, 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    dbg_addr   = '0;
    test_reset();
    test_forward();
    test_sign_wrap();
    test_jump(-1);
    test_jump(3);
    test_fetch_stall();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
